// File: rtl/throw_power_ctrl.sv
// Throw power controller: debounced button -> ping-pong charging meter -> one-cycle
// throw_trigger carrying the latched power, followed by a cooldown before re-arming.
module throw_power_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned STEP_DIV        = 65000,
  parameter int unsigned POWER_STEP      = 4,
  parameter int unsigned POWER_MIN       = 16,
  parameter int unsigned POWER_MAX       = 240,
  parameter int unsigned HOLD_TIMEOUT    = 6500000,
  parameter int unsigned COOLDOWN_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       throw_button,
  input  logic       enable,
  output logic       throw_trigger,
  output logic [7:0] power_out,
  output logic       charging,
  output logic       ready,
  output logic [1:0] o_dbg_state
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned STEP_W = $clog2(STEP_DIV + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_TIMEOUT + 1);
  localparam int unsigned CD_W   = $clog2(COOLDOWN_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_CYCLES - 1);

  localparam logic [7:0]        P_MIN8  = 8'(POWER_MIN);
  localparam logic [7:0]        P_MAX8  = 8'(POWER_MAX);
  localparam logic [8:0]        P_MAX9  = 9'(POWER_MAX);
  localparam logic [8:0]        P_STEP9 = 9'(POWER_STEP);
  localparam logic signed [9:0] P_MIN10 = 10'(POWER_MIN);
  localparam logic signed [9:0] P_STEP10 = 10'(POWER_STEP);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHARGING = 2'd1,
    S_FIRE     = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_btn_db;
  logic              r_btn_dly;
  logic [DB_W-1:0]   r_db_cnt;
  logic [7:0]        r_power;
  logic              r_dir_down;
  logic [STEP_W-1:0] r_step_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CD_W-1:0]   r_cd_cnt;
  logic              r_ready;

  logic [7:0]        w_power_next;
  logic              w_dir_next;
  logic [STEP_W-1:0] w_step_next;
  logic [HOLD_W-1:0] w_hold_next;
  logic [CD_W-1:0]   w_cd_next;
  logic              w_press;
  logic              w_release;
  logic [8:0]        w_up;
  logic signed [9:0] w_dn;
  logic              w_dn_turn;
  logic              w_up_turn;
  logic [7:0]        w_step_power;
  logic              w_step_dir;

  // Synchroniser + debounce: btn_db only follows after DEBOUNCE_CYCLES disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_btn_db  <= 1'b0;
      r_btn_dly <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= throw_button;
      r_sync2   <= r_sync1;
      r_btn_dly <= r_btn_db;
      if (r_sync2 != r_btn_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_btn_db <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_press   = r_btn_db & ~r_btn_dly;
  assign w_release = ~r_btn_db & r_btn_dly;

  // Step arithmetic is done wide so neither direction can wrap before clamping.
  assign w_up         = {1'b0, r_power} + P_STEP9;
  assign w_dn         = $signed({2'b00, r_power}) - P_STEP10;
  assign w_up_turn    = (w_up >= P_MAX9);
  assign w_dn_turn    = (w_dn <= P_MIN10);
  assign w_step_power = r_dir_down ? (w_dn_turn ? P_MIN8 : w_dn[7:0])
                                   : (w_up_turn ? P_MAX8 : w_up[7:0]);
  assign w_step_dir   = r_dir_down ? ~w_dn_turn : w_up_turn;

  always_comb begin
    w_state_next = r_state;
    w_power_next = r_power;
    w_dir_next   = r_dir_down;
    w_step_next  = r_step_cnt;
    w_hold_next  = r_hold_cnt;
    w_cd_next    = r_cd_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_press && enable) begin
          w_state_next = S_CHARGING;
          w_power_next = P_MIN8;
          w_dir_next   = 1'b0;
          w_step_next  = '0;
          w_hold_next  = '0;
        end
      end
      S_CHARGING: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end else if (w_release || (r_hold_cnt == HOLD_LAST)) begin
          w_state_next = S_FIRE;
        end else begin
          w_hold_next = r_hold_cnt + HOLD_W'(1);
          if (r_step_cnt == STEP_LAST) begin
            w_step_next  = '0;
            w_power_next = w_step_power;
            w_dir_next   = w_step_dir;
          end else begin
            w_step_next = r_step_cnt + STEP_W'(1);
          end
        end
      end
      S_FIRE: begin
        w_state_next = S_COOLDOWN;
        w_cd_next    = '0;
      end
      S_COOLDOWN: begin
        // A held button must be released before the controller re-arms.
        if (r_cd_cnt == CD_LAST) begin
          if (!r_btn_db) w_state_next = S_IDLE;
        end else begin
          w_cd_next = r_cd_cnt + CD_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_power    <= 8'd0;
      r_dir_down <= 1'b0;
      r_step_cnt <= '0;
      r_hold_cnt <= '0;
      r_cd_cnt   <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_power    <= w_power_next;
      r_dir_down <= w_dir_next;
      r_step_cnt <= w_step_next;
      r_hold_cnt <= w_hold_next;
      r_cd_cnt   <= w_cd_next;
      r_ready    <= (w_state_next == S_IDLE) && enable;
    end
  end

  assign throw_trigger = (r_state == S_FIRE);
  assign charging      = (r_state == S_CHARGING);
  assign power_out     = r_power;
  assign ready         = r_ready;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_throw_power_ctrl.sv
// Directed bench for throw_power_ctrl with small parameters; all inputs are driven and
// all outputs sampled on the falling clock edge.
module tb_throw_power_ctrl;

  logic       clk;
  logic       rst;
  logic       throw_button;
  logic       enable;
  logic       throw_trigger;
  logic [7:0] power_out;
  logic       charging;
  logic       ready;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int trig_cnt = 0;

  throw_power_ctrl #(
    .DEBOUNCE_CYCLES(3),
    .STEP_DIV(4),
    .POWER_STEP(16),
    .POWER_MIN(16),
    .POWER_MAX(240),
    .HOLD_TIMEOUT(200),
    .COOLDOWN_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .throw_button(throw_button),
    .enable(enable),
    .throw_trigger(throw_trigger),
    .power_out(power_out),
    .charging(charging),
    .ready(ready),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (throw_trigger === 1'b1) trig_cnt++;
  end

  task automatic wait_charging(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (charging === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b1;
    throw_button = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({throw_trigger, power_out, charging, ready, dbg_state} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got trig=%b pwr=%0d chg=%b rdy=%b st=%0d required all 0",
               throw_trigger, power_out, charging, ready, dbg_state);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after: got %b required 1", ready);
    end
  endtask

  task automatic test_basic_throw;
    bit ok;
    int base;
    base = trig_cnt;
    throw_button = 1'b1;
    wait_charging(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL basic_start: got no charging required charging within 20 cycles");
    end
    for (int c = 0; c <= 23; c++) begin
      if (c % 4 == 0 && c <= 20) begin
        n_cmp++;
        if (power_out !== 8'(16 + 4 * c)) begin
          n_err++;
          $display("FAIL basic_ramp c=%0d: got %0d required %0d", c, power_out, 16 + 4 * c);
        end
      end
      if (c == 16) throw_button = 1'b0;
      if (c == 22) begin
        n_cmp++;
        if (throw_trigger !== 1'b1 || power_out !== 8'd96) begin
          n_err++;
          $display("FAIL basic_fire: got trig=%b pwr=%0d required trig=1 pwr=96",
                   throw_trigger, power_out);
        end
      end
      if (c == 23) begin
        n_cmp++;
        if (throw_trigger !== 1'b0 || dbg_state !== 2'd3) begin
          n_err++;
          $display("FAIL basic_after_fire: got trig=%b st=%0d required trig=0 st=3",
                   throw_trigger, dbg_state);
        end
      end
      @(negedge clk);
    end
    wait_ready(ok);
    n_cmp++;
    if (!ok || power_out !== 8'd96 || trig_cnt - base != 1) begin
      n_err++;
      $display("FAIL basic_rearm: got ready=%b pwr=%0d triggers=%0d required ready=1 pwr=96 triggers=1",
               ok, power_out, trig_cnt - base);
    end
  endtask

  task automatic test_turnaround;
    bit ok;
    int cp_j [8] = '{0, 13, 14, 15, 16, 27, 28, 29};
    int cp_p [8] = '{16, 224, 240, 224, 208, 32, 16, 32};
    throw_button = 1'b1;
    wait_charging(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL turn_start: got no charging required charging within 20 cycles");
    end
    for (int c = 0; c <= 122; c++) begin
      for (int k = 0; k < 8; k++) begin
        if (c == cp_j[k] * 4) begin
          n_cmp++;
          if (power_out !== 8'(cp_p[k])) begin
            n_err++;
            $display("FAIL turn_step j=%0d: got %0d required %0d", cp_j[k], power_out, cp_p[k]);
          end
        end
      end
      if (c == 116) throw_button = 1'b0;
      if (c == 122) begin
        n_cmp++;
        if (throw_trigger !== 1'b1 || power_out !== 8'd48) begin
          n_err++;
          $display("FAIL turn_fire: got trig=%b pwr=%0d required trig=1 pwr=48",
                   throw_trigger, power_out);
        end
      end
      @(negedge clk);
    end
    wait_ready(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL turn_rearm: got ready=0 required ready=1");
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int base;
    base = trig_cnt;
    throw_button = 1'b1;
    wait_charging(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL tmo_start: got no charging required charging within 20 cycles");
    end
    for (int c = 0; c <= 200; c++) begin
      if (c == 199) begin
        n_cmp++;
        if (charging !== 1'b1 || power_out !== 8'd128) begin
          n_err++;
          $display("FAIL tmo_last_charge: got chg=%b pwr=%0d required chg=1 pwr=128",
                   charging, power_out);
        end
      end
      if (c == 200) begin
        n_cmp++;
        if (throw_trigger !== 1'b1 || power_out !== 8'd128) begin
          n_err++;
          $display("FAIL tmo_fire: got trig=%b pwr=%0d required trig=1 pwr=128",
                   throw_trigger, power_out);
        end
      end
      if (c < 200) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd3 || ready !== 1'b0 || trig_cnt - base != 1) begin
      n_err++;
      $display("FAIL tmo_held: got st=%0d rdy=%b triggers=%0d required st=3 rdy=0 triggers=1",
               dbg_state, ready, trig_cnt - base);
    end
    throw_button = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_ready_early: got %b required 0", ready);
    end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || power_out !== 8'd128) begin
      n_err++;
      $display("FAIL tmo_rearm: got rdy=%b pwr=%0d required rdy=1 pwr=128", ready, power_out);
    end
  endtask

  task automatic test_abort_gating;
    bit ok;
    int base;
    base = trig_cnt;
    throw_button = 1'b1;
    wait_charging(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL abort_start: got no charging required charging within 20 cycles");
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (power_out !== 8'd64) begin
      n_err++;
      $display("FAIL abort_power: got %0d required 64", power_out);
    end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (charging !== 1'b0 || dbg_state !== 2'd0 || power_out !== 8'd64) begin
      n_err++;
      $display("FAIL abort_idle: got chg=%b st=%0d pwr=%0d required chg=0 st=0 pwr=64",
               charging, dbg_state, power_out);
    end
    throw_button = 1'b0;
    repeat (10) @(negedge clk);
    throw_button = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (charging !== 1'b0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL gate_disabled_press: got chg=%b rdy=%b required chg=0 rdy=0", charging, ready);
    end
    enable = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (charging !== 1'b0 || ready !== 1'b1 || power_out !== 8'd64) begin
      n_err++;
      $display("FAIL gate_enable_rise: got chg=%b rdy=%b pwr=%0d required chg=0 rdy=1 pwr=64",
               charging, ready, power_out);
    end
    throw_button = 1'b0;
    repeat (10) @(negedge clk);
    throw_button = 1'b1;
    wait_charging(ok);
    n_cmp++;
    if (!ok || power_out !== 8'd16) begin
      n_err++;
      $display("FAIL gate_new_press: got chg=%b pwr=%0d required chg=1 pwr=16", ok, power_out);
    end
    enable = 1'b0;
    throw_button = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (trig_cnt - base != 0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_no_trigger: got triggers=%0d rdy=%b required triggers=0 rdy=1",
               trig_cnt - base, ready);
    end
  endtask

  task automatic test_bounce_and_simultaneous;
    bit ok;
    int seen;
    seen = 0;
    for (int g = 0; g < 3; g++) begin
      throw_button = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (charging !== 1'b0) seen++;
      end
      throw_button = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (charging !== 1'b0) seen++;
      end
    end
    n_cmp++;
    if (seen != 0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL bounce_glitch: got charging cycles=%0d st=%0d required 0 and 0", seen, dbg_state);
    end
    throw_button = 1'b1;
    wait_charging(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL simul_start: got no charging required charging within 20 cycles");
    end
    for (int c = 0; c <= 24; c++) begin
      if (c == 18) throw_button = 1'b0;
      if (c == 23) begin
        n_cmp++;
        if (charging !== 1'b1 || power_out !== 8'd96) begin
          n_err++;
          $display("FAIL simul_pre: got chg=%b pwr=%0d required chg=1 pwr=96", charging, power_out);
        end
      end
      if (c == 24) begin
        n_cmp++;
        if (throw_trigger !== 1'b1 || power_out !== 8'd96) begin
          n_err++;
          $display("FAIL simul_fire: got trig=%b pwr=%0d required trig=1 pwr=96",
                   throw_trigger, power_out);
        end
      end
      if (c < 24) @(negedge clk);
    end
    wait_ready(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL simul_rearm: got ready=0 required ready=1");
    end
  endtask

  task automatic test_reset_midcharge;
    bit ok;
    int base;
    base = trig_cnt;
    throw_button = 1'b1;
    wait_charging(ok);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (!ok || power_out !== 8'd96) begin
      n_err++;
      $display("FAIL midrst_power: got chg=%b pwr=%0d required chg=1 pwr=96", ok, power_out);
    end
    rst = 1'b1;
    throw_button = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({throw_trigger, power_out, charging, ready, dbg_state} !== 13'd0) begin
      n_err++;
      $display("FAIL midrst_outputs: got trig=%b pwr=%0d chg=%b rdy=%b st=%0d required all 0",
               throw_trigger, power_out, charging, ready, dbg_state);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (trig_cnt - base != 0 || ready !== 1'b1 || charging !== 1'b0 || power_out !== 8'd0) begin
      n_err++;
      $display("FAIL midrst_after: got triggers=%0d rdy=%b chg=%b pwr=%0d required 0/1/0/0",
               trig_cnt - base, ready, charging, power_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    throw_button = 1'b0;
    test_reset;
    test_basic_throw;
    test_turnaround;
    test_timeout;
    test_abort_gating;
    test_bounce_and_simultaneous;
    test_reset_midcharge;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/throw_power_ctrl.md
Name: throw_power_ctrl

Overview:
Converts a held throw button into a charging power meter and a single throw_trigger pulse carrying the latched power.
Sits between the board button input and the turn controller. It drives that controller's throw_trigger/throw_power inputs and paces turns through enable and a post-throw cooldown.
It also exports the live meter value for the power-bar renderer.

Parameters:
DEBOUNCE_CYCLES, 650000, consecutive stable cycles required before the debounced button changes.
STEP_DIV, 65000, clock cycles per power step while charging.
POWER_STEP, 4, power increment/decrement per step (8-bit).
POWER_MIN, 16, charge start value and lower turnaround.
POWER_MAX, 240, upper turnaround (POWER_MIN < POWER_MAX <= 255).
HOLD_TIMEOUT, 6500000, maximum CHARGING cycles before an automatic fire.
COOLDOWN_CYCLES, 2000000, dead time after a fire.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
throw_button  in  1  raw asynchronous button, high = pressed
enable  in  1  throwing permitted (current player's turn, not in transition)
throw_trigger  out  1  one-cycle pulse on fire
power_out  out  8  live meter while charging; frozen fired value otherwise
charging  out  1  high in CHARGING
ready  out  1  high in IDLE with enable=1

Behaviour:
- Reset (single clk edge with rst=1), from any state including mid-charge:
  - state=IDLE, throw_trigger=0, power_out=0, charging=0, ready=0 (registered).
  - Synchroniser, debounce counter, step/hold/cooldown counters cleared; btn_db=0; dir=up.
  - No trigger is emitted because of reset.
- Input path:
  - 2-flop synchroniser, then debounce.
  - btn_db takes the synchronised value only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement clears the counter.
  - Edges (press/release) are derived from btn_db versus its 1-cycle-delayed copy.
- IDLE:
  - press && enable -> CHARGING; power_out<=POWER_MIN, dir<=up, step_cnt<=0, hold_cnt<=0.
  - A press with enable=0 is discarded. A later rise of enable while the button is held does not start a charge; a new press is required.
- CHARGING, per cycle, in priority order:
  1. enable=0 -> IDLE (abort). No trigger; power_out keeps its current value.
  2. release, or hold_cnt==HOLD_TIMEOUT-1 -> FIRE. No step applied this cycle; exactly one fire even if both conditions occur together.
  3. step_cnt==STEP_DIV-1 -> step_cnt<=0 and apply a step; otherwise step_cnt++. hold_cnt++ every cycle.
- Step arithmetic (9-bit, no wrap):
  - dir=up: n=power+POWER_STEP. If n>=POWER_MAX, power=POWER_MAX and dir=down; else power=n.
  - dir=down: n=power-POWER_STEP (signed). If n<=POWER_MIN, power=POWER_MIN and dir=up; else power=n.
- FIRE:
  - Lasts exactly one cycle; throw_trigger=1 in that cycle only.
  - power_out holds the fired value, stable from that cycle until the next charge starts.
  - Always -> COOLDOWN, regardless of enable.
- COOLDOWN:
  - Counts COOLDOWN_CYCLES.
  - Then -> IDLE only once btn_db=0; otherwise waits (a timeout fire with the button held needs a release before re-arming).
  - Presses during COOLDOWN are ignored.
- charging and ready are decoded from the registered state. Latency from the debounced press edge to charging=1 is 1 cycle.

Test Plan (DEBOUNCE_CYCLES=3, STEP_DIV=4, POWER_STEP=16, POWER_MIN=16, POWER_MAX=240, HOLD_TIMEOUT=200, COOLDOWN_CYCLES=10):
- Reset mid-charge: assert rst while power_out=96 -> next edge: all outputs 0, state IDLE; no throw_trigger pulse at any time.
- Basic throw: enable=1, press, hold through 5 steps, release -> power_out ramps 16,32,48,64,80,96; exactly one throw_trigger with power_out=96; power_out stays 96 through COOLDOWN and IDLE.
- Turnaround: hold 14 steps -> power_out=240 and dir flips; next step gives 224. Continue to 16, then up again.
- Timeout: hold indefinitely -> fire on CHARGING cycle 199 after 49 steps with power_out=128. No re-arm until release plus 10 cooldown cycles; then ready=1.
- Abort and gating: drop enable at power 64 -> IDLE, no trigger. Press while enable=0, then raise enable while still held -> no charge. Release and press again -> charge starts at 16.
- Bounce/simultaneity: 2-cycle glitches on throw_button -> no charge. Release coinciding with a step cycle -> fired power is the pre-step value.
